// File: rtl/mult_div_unit_pkg.sv
// Shared types for the multiply/divide unit: op codes, FSM states, op decode helpers.
// Also imported by main-decoder control generation so op encodings stay in one place.
package mult_div_unit_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_signed(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between EX and the multiply/divide unit.
// master = EX stage / hazard unit side, slave = the unit itself.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  import mult_div_unit_pkg::*;

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, In1, In2, hi_we, lo_we,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, In1, In2, hi_we, lo_we,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/mult_div_unit_abs_neg.sv
// Conditional two's-complement: y = neg ? -a : a. Purely combinational.
// Used for operand magnitudes at accept and for result sign fix-up.
module mult_div_unit_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (WIDTH'(0) - a) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; one result bit per cycle.
// Fixed latency WIDTH+2 edges from accept to HI/LO write; start is ignored while busy.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH + 1;

  state_e           state, state_nxt;
  op_e              op_q;
  logic [CW-1:0]    count;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] opb;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic             sgn_in;
  logic [WIDTH-1:0] abs_in1, abs_in2;

  assign sgn_in = op_is_signed(bus.op);

  mult_div_unit_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
    .neg (sgn_in & bus.In1[WIDTH-1]),
    .a   (bus.In1),
    .y   (abs_in1)
  );

  mult_div_unit_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
    .neg (sgn_in & bus.In2[WIDTH-1]),
    .a   (bus.In2),
    .y   (abs_in2)
  );

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  logic [WIDTH:0]  upper, mul_sum, div_diff;
  logic [AW-1:0]   mul_step, div_shift, div_step, acc_step;

  always_comb begin
    upper     = acc[AW-1:WIDTH];
    mul_sum   = acc[0] ? (upper + {1'b0, opb}) : upper;
    mul_step  = {1'b0, mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[AW-2:0], 1'b0};
    div_diff  = div_shift[AW-1:WIDTH] - {1'b0, opb};
    div_step  = div_diff[WIDTH] ? div_shift
                                : {div_diff, div_shift[WIDTH-1:1], 1'b1};
    acc_step  = op_is_div(op_q) ? div_step : mul_step;
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   hi_res, lo_res;

  mult_div_unit_abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
    .neg (sign_a ^ sign_b),
    .a   (acc[2*WIDTH-1:0]),
    .y   (prod_fix)
  );

  mult_div_unit_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .neg (sign_a ^ sign_b),
    .a   (acc[WIDTH-1:0]),
    .y   (quo_fix)
  );

  // Remainder takes the sign of the dividend.
  mult_div_unit_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .neg (sign_a),
    .a   (acc[2*WIDTH-1:WIDTH]),
    .y   (rem_fix)
  );

  // Divide by zero leaves the dividend in the remainder naturally; only the quotient is forced.
  always_comb begin
    if (op_is_div(op_q)) begin
      hi_res = rem_fix;
      lo_res = (opb == '0) ? '1 : quo_fix;
    end else begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // RUN holds one extra cycle at count==WIDTH so every op lands at exactly WIDTH+2 edges.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.start)           state_nxt = ST_RUN;
      ST_RUN:  if (count == CW'(WIDTH)) state_nxt = ST_FIX;
      ST_FIX:                           state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != ST_IDLE);
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MULT;
      count  <= '0;
      acc    <= '0;
      opb    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            count  <= '0;
            sign_a <= sgn_in & bus.In1[WIDTH-1];
            sign_b <= sgn_in & bus.In2[WIDTH-1];
            if (op_is_div(bus.op)) begin
              acc <= {{(WIDTH+1){1'b0}}, abs_in1};
              opb <= abs_in2;
            end else begin
              acc <= {{(WIDTH+1){1'b0}}, abs_in2};
              opb <= abs_in1;
            end
          end else begin
            if (bus.hi_we) hi_q <= bus.In1;
            if (bus.lo_we) lo_q <= bus.In1;
          end
        end
        ST_RUN: begin
          if (count != CW'(WIDTH)) begin
            acc   <= acc_step;
            count <= count + CW'(1);
          end
        end
        ST_FIX: begin
          hi_q   <= hi_res;
          lo_q   <= lo_res;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
